// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the CPU and a host/loader port.
// The host is granted only at instruction boundaries, for bursts of at most MAX_BURST accesses.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic {
    RUN  = 1'b0,
    HOST = 1'b1
  } state_t;

  state_t           state;
  logic             phase;
  logic [CNT_W-1:0] cnt;
  logic             host_owns;

  // phase mirrors the CPU's fetch/execute alternation; it freezes while the CPU is stalled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        RUN: begin
          if (phase && host_req) begin
            state <= HOST;
            phase <= 1'b0;
            cnt   <= '0;
          end else begin
            phase <= ~phase;
          end
        end
        HOST: begin
          if (host_req && (cnt != CNT_LAST)) begin
            cnt <= cnt + CNT_W'(1);
          end else begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        default: begin
          state <= RUN;
          phase <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign host_owns = (state == HOST);

  // An idle HOST cycle (no request) must not write memory even if host_we is left high
  assign cpu_stall   = host_owns;
  assign host_ack    = host_owns & host_req;
  assign mem_address = host_owns ? host_address : cpu_address;
  assign mem_wdata   = host_owns ? host_wdata : cpu_wdata;
  assign mem_we      = host_owns ? (host_req & host_we) : cpu_we;

  assign cpu_rdata  = mem_rdata;
  assign host_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table vectors, directed corner sequences and a random
// phase checked against an ownership/burst reference model plus a shadow memory.
module tb_mem_arbiter;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_address;
  logic [DATA_W-1:0] host_wdata;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic check_en = 1'b0;

  always #5 clock = ~clock;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cpu_address(cpu_address),
    .cpu_we(cpu_we),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .host_req(host_req),
    .host_we(host_we),
    .host_address(host_address),
    .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .host_ack(host_ack),
    .mem_address(mem_address),
    .mem_we(mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory behind the arbiter; all stimulus addresses stay below 0x100
  logic [31:0] mem [256];
  logic mem_ready = 1'b0;
  assign mem_rdata = mem[mem_address[7:0]];

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h20] <= 32'hDEADBEEF;
      mem_ready  <= 1'b1;
    end else if (mem_we) begin
      mem[mem_address[7:0]] <= mem_wdata;
    end
  end

  // Reference model: host_slot < 0 means the CPU owns the bus, otherwise it counts
  // host accesses done in this grant; run_cycles counts CPU cycles since RUN began.
  logic [31:0] ref_mem [256];
  logic ref_ready = 1'b0;
  int run_cycles;
  int host_slot;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      run_cycles <= 0;
      host_slot  <= -1;
      if (!ref_ready) begin
        for (int i = 0; i < 256; i++) ref_mem[i] <= '0;
        ref_mem[8'h20] <= 32'hDEADBEEF;
        ref_ready <= 1'b1;
      end
    end else if (host_slot < 0) begin
      if (cpu_we) ref_mem[cpu_address[7:0]] <= cpu_wdata;
      if ((run_cycles % 2 == 1) && host_req) begin
        host_slot  <= 0;
        run_cycles <= 0;
      end else begin
        run_cycles <= run_cycles + 1;
      end
    end else if (host_req) begin
      if (host_we) ref_mem[host_address[7:0]] <= host_wdata;
      if (host_slot + 1 == MAX_BURST) begin
        host_slot  <= -1;
        run_cycles <= 0;
      end else begin
        host_slot <= host_slot + 1;
      end
    end else begin
      host_slot  <= -1;
      run_cycles <= 0;
    end
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin : model_check
    logic owns;
    logic [15:0] e_addr;
    logic e_we;
    logic [31:0] e_wdata;
    if (check_en) begin
      owns    = (host_slot >= 0);
      e_addr  = owns ? host_address : cpu_address;
      e_we    = owns ? (host_req & host_we) : cpu_we;
      e_wdata = owns ? host_wdata : cpu_wdata;
      check_output("model_cpu_stall", 64'(cpu_stall), 64'(owns));
      check_output("model_host_ack", 64'(host_ack), 64'(owns & host_req));
      check_output("model_mem_address", 64'(mem_address), 64'(e_addr));
      check_output("model_mem_we", 64'(mem_we), 64'(e_we));
      if (e_we) check_output("model_mem_wdata", 64'(mem_wdata), 64'(e_wdata));
      check_output("model_host_rdata", 64'(host_rdata), 64'(mem_rdata));
      check_output("model_cpu_rdata", 64'(cpu_rdata), 64'(mem_rdata));
    end
  end

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic        cpu_we;
    logic        exp_stall;
    logic        exp_ack;
    logic        exp_mem_we;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  function automatic vec_t mk(input logic req, input logic we, input logic [15:0] haddr,
                              input logic [31:0] hwdata, input logic cwe, input logic st,
                              input logic ack, input logic mwe, input logic chk,
                              input logic [31:0] rd);
    vec_t v;
    v.req = req; v.we = we; v.haddr = haddr; v.hwdata = hwdata; v.cpu_we = cwe;
    v.exp_stall = st; v.exp_ack = ack; v.exp_mem_we = mwe; v.chk_rdata = chk; v.exp_rdata = rd;
    return v;
  endfunction

  task automatic apply_stimulus(input vec_t v, input int idx);
    host_req     = v.req;
    host_we      = v.we;
    host_address = v.haddr;
    host_wdata   = v.hwdata;
    cpu_we       = v.cpu_we;
    cpu_address  = 16'h0080 + 16'(idx);
    cpu_wdata    = 32'hC000_0000 + 32'(idx);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    host_req = 1'b0;
    cpu_we   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin : main
    vec_t vecs [16];
    logic [15:0] pattern;
    int n;
    int wait_cnt;
    int bad;
    logic last_ack;

    vecs[0]  = mk(1, 0, 16'h20, 32'h0,  0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 0, 16'h20, 32'h0,  0, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(1, 0, 16'h20, 32'h0,  0, 1, 1, 0, 1, 32'hDEADBEEF);
    vecs[3]  = mk(0, 0, 16'h20, 32'h0,  0, 1, 0, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 16'h20, 32'h0,  1, 0, 0, 1, 0, 32'h0);
    vecs[5]  = mk(1, 1, 16'h50, 32'h11, 0, 0, 0, 0, 0, 32'h0);
    vecs[6]  = mk(1, 1, 16'h50, 32'h11, 0, 1, 1, 1, 0, 32'h0);
    vecs[7]  = mk(0, 1, 16'h50, 32'h11, 0, 1, 0, 0, 0, 32'h0);
    vecs[8]  = mk(1, 0, 16'h20, 32'h0,  0, 0, 0, 0, 0, 32'h0);
    vecs[9]  = mk(1, 0, 16'h20, 32'h0,  0, 0, 0, 0, 0, 32'h0);
    vecs[10] = mk(1, 0, 16'h20, 32'h0,  1, 1, 1, 0, 1, 32'hDEADBEEF);
    vecs[11] = mk(0, 0, 16'h20, 32'h0,  0, 1, 0, 0, 0, 32'h0);
    vecs[12] = mk(1, 0, 16'h20, 32'h0,  0, 0, 0, 0, 0, 32'h0);
    vecs[13] = mk(1, 0, 16'h20, 32'h0,  0, 0, 0, 0, 0, 32'h0);
    vecs[14] = mk(1, 0, 16'h20, 32'h0,  0, 1, 1, 0, 1, 32'hDEADBEEF);
    vecs[15] = mk(0, 0, 16'h20, 32'h0,  0, 1, 0, 0, 0, 32'h0);

    reset        = 1'b0;
    host_req     = 1'b1;
    host_we      = 1'b0;
    host_address = 16'h0020;
    host_wdata   = '0;
    cpu_address  = 16'h0011;
    cpu_we       = 1'b0;
    cpu_wdata    = '0;
    check_en     = 1'b1;

    // Reset held with a pending host request: CPU keeps the bus
    repeat (3) begin
      @(negedge clock);
      check_output("reset_cpu_stall", 64'(cpu_stall), 64'd0);
      check_output("reset_host_ack", 64'(host_ack), 64'd0);
      check_output("reset_mem_address", 64'(mem_address), 64'h0011);
    end
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i], i);
      @(negedge clock);
      check_output($sformatf("row%0d_stall", i), 64'(cpu_stall), 64'(vecs[i].exp_stall));
      check_output($sformatf("row%0d_ack", i), 64'(host_ack), 64'(vecs[i].exp_ack));
      check_output($sformatf("row%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].exp_mem_we));
      check_output($sformatf("row%0d_mem_address", i), 64'(mem_address),
                   64'(vecs[i].exp_stall ? vecs[i].haddr : 16'h0080 + 16'(i)));
      if (vecs[i].chk_rdata)
        check_output($sformatf("row%0d_host_rdata", i), 64'(host_rdata), 64'(vecs[i].exp_rdata));
      next_cycle();
    end
    check_output("row6_write_landed", 64'(mem[8'h50]), 64'h11);

    // Ten back-to-back host writes split by the burst cap
    do_reset();
    cpu_address = 16'h00F0;
    n = 0;
    pattern = '0;
    for (int c = 0; c < 40; c++) begin
      host_req     = (n < 10);
      host_we      = 1'b1;
      host_address = 16'h0040 + 16'(n);
      host_wdata   = 32'h1000 + 32'(n);
      @(negedge clock);
      if (c < 16) pattern = {pattern[14:0], host_ack};
      if (host_ack) n++;
      next_cycle();
    end
    check_output("burst_ack_pattern", 64'(pattern), 64'(16'b0011110011110011));
    check_output("burst_ack_count", 64'(n), 64'd10);
    for (int i = 0; i < 10; i++)
      check_output($sformatf("burst_word%0d", i), 64'(mem[8'h40 + 8'(i)]), 64'(32'h1000 + 32'(i)));

    // Reset during the second access of a burst
    do_reset();
    n = 0;
    host_we = 1'b1;
    for (int c = 0; c < 10 && n < 1; c++) begin
      host_req     = 1'b1;
      host_address = 16'h0060;
      host_wdata   = 32'h2000;
      @(negedge clock);
      if (host_ack) n++;
      next_cycle();
    end
    check_output("midburst_first_ack", 64'(n), 64'd1);
    host_address = 16'h0061;
    host_wdata   = 32'h2001;
    #1;
    check_output("midburst_stall_before_reset", 64'(cpu_stall), 64'd1);
    reset = 1'b0;
    #1;
    check_output("midburst_reset_stall", 64'(cpu_stall), 64'd0);
    check_output("midburst_reset_ack", 64'(host_ack), 64'd0);
    check_output("midburst_reset_mem_we", 64'(mem_we), 64'd0);
    check_output("midburst_reset_address", 64'(mem_address), 64'(cpu_address));
    next_cycle();
    host_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    check_output("midburst_no_write", 64'(mem[8'h61]), 64'h0);
    check_output("midburst_first_write", 64'(mem[8'h60]), 64'h2000);

    // CPU store and host write interleaved
    cpu_address  = 16'h0030;
    cpu_wdata    = 32'h5;
    cpu_we       = 1'b1;
    host_req     = 1'b1;
    host_we      = 1'b1;
    host_address = 16'h0031;
    host_wdata   = 32'hA;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (host_ack) n++;
      next_cycle();
      if (n > 0) host_req = 1'b0;
    end
    cpu_we = 1'b0;
    check_output("coexist_ack_count", 64'(n), 64'd1);
    check_output("coexist_cpu_word", 64'(mem[8'h30]), 64'h5);
    check_output("coexist_host_word", 64'(mem[8'h31]), 64'hA);

    // Random traffic; the host holds each request until it is acknowledged
    host_req = 1'b0;
    last_ack = 1'b0;
    wait_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!host_req || last_ack) begin
        host_req     = ($urandom_range(0, 9) < 6);
        host_we      = 1'($urandom_range(0, 1));
        host_address = 16'($urandom_range(0, 255));
        host_wdata   = $urandom;
      end
      cpu_address = 16'($urandom_range(0, 255));
      cpu_we      = ($urandom_range(0, 9) < 3);
      cpu_wdata   = $urandom;
      @(negedge clock);
      last_ack = host_ack;
      if (host_req) begin
        wait_cnt++;
        if (host_ack) begin
          check_output("host_latency_in_range", 64'(wait_cnt >= 1 && wait_cnt <= 3), 64'd1);
          wait_cnt = 0;
        end else if (wait_cnt == 4) begin
          check_output("host_latency_bound", 64'(wait_cnt), 64'd3);
        end
      end else begin
        wait_cnt = 0;
      end
      next_cycle();
    end
    host_req = 1'b0;
    cpu_we   = 1'b0;
    repeat (4) next_cycle();

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    check_output("memory_image_differences", 64'(bad), 64'd0);

    check_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
